// File: rtl/n_bit_pipe_csa_adder.sv
// ---------------------------------------------------------------------------
// n_bit_pipe_csa_adder
//
// Pipelined carry-select adder/subtractor for the FIR datapath.
//
// Segmentation and pipeline
//   - The operands are cut into SEG_WIDTH-bit segments.
//   - Stage k resolves segment k. It forms both candidate sums (carry-in 0
//     and carry-in 1) and picks one with the carry registered by stage k-1.
//   - Stage 0 works directly on the input port values. The last stage
//     feeds the output register. Latency is therefore NUM_SEG enabled edges.
//
// Ports
//   clk, rst        clock; synchronous active-high reset (wins over en)
//   en              pipeline advance; 0 freezes every register
//   in_valid        qualifies in1/in2/cin/sub
//   in1, in2        unsigned operands
//   cin             carry-in for adds; ignored when sub=1
//   sub             1: in1 - in2 computed as in1 + ~in2 + 1
//   out_valid       sum carries a new result this cycle
//   sum             {carry_out, result}; for subtract, MSB=1 means no borrow
// ---------------------------------------------------------------------------
module n_bit_pipe_csa_adder #(
    parameter int IN_DATAWIDTH  = 16,
    parameter int SEG_WIDTH     = 4,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [IN_DATAWIDTH-1:0]  in1,
    input  logic [IN_DATAWIDTH-1:0]  in2,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    output logic [OUT_DATAWIDTH-1:0] sum
);

    localparam int NUM_SEG = (IN_DATAWIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int LAST    = NUM_SEG - 1;

    // Stage-k inputs: skewed operands, partially resolved result, carry
    // into segment k, and valid.
    logic [IN_DATAWIDTH-1:0] cur_a [NUM_SEG];
    logic [IN_DATAWIDTH-1:0] cur_b [NUM_SEG];
    logic [IN_DATAWIDTH-1:0] cur_r [NUM_SEG];
    logic                    cur_c [NUM_SEG];
    logic                    cur_v [NUM_SEG];

    // Stage-k combinational outputs: result with segment k filled in, and
    // the carry out of segment k.
    logic [IN_DATAWIDTH-1:0] r_d [NUM_SEG];
    logic                    c_d [NUM_SEG];

    // Subtract is folded in at capture time. B is inverted and the carry
    // is forced to 1. After that, sub needs no further pipelining: the
    // transaction already carries its mode in its operands.
    assign cur_a[0] = in1;
    assign cur_b[0] = sub ? ~in2 : in2;
    assign cur_c[0] = sub ? 1'b1 : cin;
    assign cur_v[0] = in_valid;
    assign cur_r[0] = '0;

    genvar k;
    generate
        for (k = 0; k < NUM_SEG; k++) begin : g_stage
            localparam int LO = k * SEG_WIDTH;
            // The top segment is narrower when the width does not divide evenly.
            localparam int SW = ((IN_DATAWIDTH - LO) < SEG_WIDTH) ? (IN_DATAWIDTH - LO) : SEG_WIDTH;

            logic [SW-1:0] a_seg;
            logic [SW-1:0] b_seg;
            logic [SW:0]   sum0;
            logic [SW:0]   sum1;
            logic [SW:0]   sel;

            assign a_seg = cur_a[k][LO +: SW];
            assign b_seg = cur_b[k][LO +: SW];
            assign sum0  = {1'b0, a_seg} + {1'b0, b_seg};
            assign sum1  = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, 1'b1};
            assign sel   = cur_c[k] ? sum1 : sum0;

            // Bits at and above segment k are still zero in cur_r, so OR-ing
            // the new segment in is enough.
            assign r_d[k] = cur_r[k] | (IN_DATAWIDTH'(sel[SW-1:0]) << LO);
            assign c_d[k] = sel[SW];

            if (k < LAST) begin : g_reg
                // Operand registers are kept full width for simplicity.
                // Segments already consumed have no downstream load, so
                // synthesis trims them. Only the upper segments are truly
                // delayed.
                logic [IN_DATAWIDTH-1:0] a_q;
                logic [IN_DATAWIDTH-1:0] b_q;
                logic [IN_DATAWIDTH-1:0] r_q;
                logic                    c_q;
                logic                    v_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                        r_q <= '0;
                        c_q <= 1'b0;
                        v_q <= 1'b0;
                    end else if (en) begin
                        a_q <= cur_a[k];
                        b_q <= cur_b[k];
                        r_q <= r_d[k];
                        c_q <= c_d[k];
                        v_q <= cur_v[k];
                    end
                end

                assign cur_a[k+1] = a_q;
                assign cur_b[k+1] = b_q;
                assign cur_r[k+1] = r_q;
                assign cur_c[k+1] = c_q;
                assign cur_v[k+1] = v_q;
            end
        end
    endgenerate

    // Output register. sum only loads when a valid transaction completes,
    // so it keeps the last result across bubbles. out_valid follows the
    // final-stage valid bit on every enabled edge.
    logic [OUT_DATAWIDTH-1:0] sum_d;
    logic [OUT_DATAWIDTH-1:0] sum_q;
    logic                     out_valid_d;
    logic                     out_valid_q;

    always_comb begin
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (en) begin
            out_valid_d = cur_v[LAST];
            if (cur_v[LAST]) begin
                sum_d = {c_d[LAST], r_d[LAST]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_n_bit_pipe_csa_adder.sv
module tb_n_bit_pipe_csa_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default 16/4 instance
    logic        rst, en, in_valid, cin, sub;
    logic [15:0] in1, in2;
    logic        out_valid;
    logic [16:0] sum;

    // Odd-width 10/4 instance
    logic        o_rst, o_en, o_in_valid, o_cin, o_sub;
    logic [9:0]  o_in1, o_in2;
    logic        o_out_valid;
    logic [10:0] o_sum;

    n_bit_pipe_csa_adder #(.IN_DATAWIDTH(16), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in1(in1), .in2(in2), .cin(cin), .sub(sub),
        .out_valid(out_valid), .sum(sum)
    );

    n_bit_pipe_csa_adder #(.IN_DATAWIDTH(10), .SEG_WIDTH(4)) dut_o (
        .clk(clk), .rst(o_rst), .en(o_en), .in_valid(o_in_valid),
        .in1(o_in1), .in2(o_in2), .cin(o_cin), .sub(o_sub),
        .out_valid(o_out_valid), .sum(o_sum)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] exp;
    } vec_t;

    vec_t        tbl [24];
    logic [16:0] exp_q [$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    bit          mon_on = 1'b0;
    logic [16:0] prev_sum;
    logic        prev_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        logic en_s;
        en_s = en;
        @(posedge clk);
        #1;
        if (mon_on) begin
            if (!en_s) begin
                chk("stall_sum_frozen", sum, prev_sum);
                chk("stall_valid_frozen", out_valid, prev_ov);
            end else if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
                else chk("stream_result", sum, exp_q.pop_front());
            end
        end
        prev_sum = sum;
        prev_ov  = out_valid;
    endtask

    int lat;
    int ov_seen;

    initial begin
        // Directed vectors: stream, then subtracts interleaved with adds.
        for (int i = 0; i < 16; i++) begin
            tbl[i].a   = 16'(i * 16'h1111);
            tbl[i].b   = 16'(i * 16'h1111);
            tbl[i].cin = 1'b1;
            tbl[i].sub = 1'b0;
            tbl[i].exp = 17'(i * 17'h2222 + 1);
        end
        tbl[16] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE};
        tbl[17] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 17'h02234};
        tbl[18] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002};
        tbl[19] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000};
        tbl[20] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h10000}; // cin ignored on sub
        tbl[21] = '{16'h1000, 16'h1001, 1'b0, 1'b1, 17'h0FFFF};
        tbl[22] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF};
        tbl[23] = '{16'h0003, 16'hFFFF, 1'b0, 1'b1, 17'h00004};

        rst = 1'b1; en = 1'b1; in_valid = 1'b1; cin = 1'b1; sub = 1'b0;
        in1 = 16'($urandom); in2 = 16'($urandom);
        o_rst = 1'b1; o_en = 1'b1; o_in_valid = 1'b0; o_cin = 1'b0; o_sub = 1'b0;
        o_in1 = '0; o_in2 = '0;

        // Reset with valid traffic present
        repeat (2) begin
            tick();
            chk("reset_sum", sum, 0);
            chk("reset_valid", out_valid, 0);
            in1 = 16'($urandom); in2 = 16'($urandom);
        end
        rst = 1'b0; o_rst = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_reset_valid", out_valid, 0);
        chk("post_reset_sum", sum, 0);

        // Full carry ripple: latency and single-cycle pulse
        in1 = 16'hFFFF; in2 = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin tick(); lat++; end
        chk("ripple_latency", lat, 4);
        chk("ripple_sum", sum, 17'h10000);
        tick();
        chk("ripple_pulse_width", out_valid, 0);
        chk("ripple_sum_hold", sum, 17'h10000);

        // Table run with a 3-cycle stall inside the stream
        mon_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 7) begin
                en = 1'b0; in_valid = 1'b1; in1 = 16'hDEAD; in2 = 16'hBEEF;
                repeat (3) tick();
                en = 1'b1;
            end
            in1 = tbl[i].a; in2 = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub;
            in_valid = 1'b1;
            exp_q.push_back(tbl[i].exp);
            tick();
        end
        in_valid = 1'b0; sub = 1'b0;
        repeat (8) tick();
        chk("all_results_delivered", exp_q.size(), 0);
        mon_on = 1'b0;

        // Odd width 10/4: three stages, narrow top segment
        o_in1 = 10'h3FF; o_in2 = 10'h001; o_cin = 1'b0; o_in_valid = 1'b1;
        tick();
        o_in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 10) begin tick(); lat++; end
        chk("odd_latency", lat, 3);
        chk("odd_sum", o_sum, 11'h400);

        // Two transactions in flight, then reset while stalled
        o_in1 = 10'h123; o_in2 = 10'h0F0; o_in_valid = 1'b1;
        tick();
        o_in1 = 10'h200; o_sub = 1'b1;
        tick();
        o_in_valid = 1'b0; o_sub = 1'b0; o_en = 1'b0; o_rst = 1'b1;
        tick();
        chk("odd_rst_sum", o_sum, 0);
        chk("odd_rst_valid", o_out_valid, 0);
        o_rst = 1'b0; o_en = 1'b1;
        ov_seen = 0;
        repeat (6) begin
            tick();
            if (o_out_valid) ov_seen++;
        end
        chk("odd_no_ghost_valid", ov_seen, 0);

        // A new transaction after reset still goes through
        o_in1 = 10'h155; o_in2 = 10'h0AA; o_cin = 1'b1; o_in_valid = 1'b1;
        tick();
        o_in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 10) begin tick(); lat++; end
        chk("odd_after_reset_latency", lat, 3);
        chk("odd_after_reset_sum", o_sum, 11'h200);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
